// File: rtl/rvecc_encode_stream.sv
// Pipelined SECDED encoder for streamed write data, with a one-shot error-injection
// facility and a saturating count of accepted words.
module rvecc_encode_stream #(
  parameter int unsigned DW   = 32,
  parameter int unsigned CNTW = 16,
  // K+1, where K is the smallest value with 2^K >= DW+K+1 (valid for DW in 1..120).
  localparam int unsigned ECCW = (DW <= 32'd1)  ? 32'd3 :
                                 (DW <= 32'd4)  ? 32'd4 :
                                 (DW <= 32'd11) ? 32'd5 :
                                 (DW <= 32'd26) ? 32'd6 :
                                 (DW <= 32'd57) ? 32'd7 : 32'd8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  input  logic                 inj_arm,
  input  logic [DW+ECCW-1:0]   inj_mask,
  output logic                 inj_pending,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [ECCW-1:0]      out_ecc,
  output logic                 out_injected,
  output logic [CNTW-1:0]      enc_count
);

  localparam int unsigned K   = ECCW - 1;
  localparam int unsigned CWW = DW + ECCW;

  typedef struct packed {
    logic            inj;
    logic [ECCW-1:0] ecc;
    logic [DW-1:0]   data;
  } entry_t;

  // Data bit n occupies the (n+1)-th non-power-of-two codeword position; check bit j
  // covers every data bit whose position has bit j set.
  function automatic logic [DW-1:0] check_mask(int unsigned j);
    logic [DW-1:0] m;
    int unsigned   n;
    m = '0;
    n = 0;
    for (int unsigned p = 1; n < DW; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (((p >> j) & 32'd1) != 0) begin
          m = m | (DW'(1) << n);
        end
        n++;
      end
    end
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // Combinational encoder
  // ---------------------------------------------------------------------------
  logic [ECCW-1:0] enc_ecc;

  for (genvar j = 0; j < K; j++) begin : g_check
    localparam logic [DW-1:0] CheckMask = check_mask(j);
    assign enc_ecc[j] = ^(in_data & CheckMask);
  end

  assign enc_ecc[K] = (^in_data) ^ (^enc_ecc[K-1:0]);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             main_valid_q, main_valid_d;
  entry_t           main_q, main_d;
  logic             skid_valid_q, skid_valid_d;
  entry_t           skid_q, skid_d;
  logic             inj_pending_q, inj_pending_d;
  logic [CWW-1:0]   inj_mask_q, inj_mask_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic             accept;
  logic             drain;
  logic             apply;
  logic [CWW-1:0]   flip;
  logic [CWW-1:0]   enc_cw;
  entry_t           new_entry;

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign drain    = main_valid_q & out_ready;

  // Only a mask armed in an earlier cycle may hit the beat accepted now.
  assign apply    = accept & inj_pending_q;
  assign flip     = apply ? inj_mask_q : '0;
  assign enc_cw   = {enc_ecc, in_data} ^ flip;

  always_comb begin
    new_entry      = '0;
    new_entry.inj  = apply;
    new_entry.ecc  = enc_cw[CWW-1:DW];
    new_entry.data = enc_cw[DW-1:0];
  end

  // Output stage: main presents the beat; skid catches one beat while main stalls.
  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;

    if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_d       = new_entry;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = new_entry;
    end
  end

  always_comb begin
    inj_pending_d = inj_pending_q;
    inj_mask_d    = inj_mask_q;
    if (inj_arm) begin
      inj_pending_d = 1'b1;
      inj_mask_d    = inj_mask;
    end else if (apply) begin
      inj_pending_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q  <= 1'b0;
      main_q        <= '0;
      skid_valid_q  <= 1'b0;
      skid_q        <= '0;
      inj_pending_q <= 1'b0;
      inj_mask_q    <= '0;
      cnt_q         <= '0;
    end else begin
      main_valid_q  <= main_valid_d;
      main_q        <= main_d;
      skid_valid_q  <= skid_valid_d;
      skid_q        <= skid_d;
      inj_pending_q <= inj_pending_d;
      inj_mask_q    <= inj_mask_d;
      cnt_q         <= cnt_d;
    end
  end

  assign out_valid    = main_valid_q;
  assign out_data     = main_q.data;
  assign out_ecc      = main_q.ecc;
  assign out_injected = main_q.inj;
  assign inj_pending  = inj_pending_q;
  assign enc_count    = cnt_q;

endmodule
